// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_size_e  : access size encoding as produced by the decoder
//   lsu_state_e : LSU control states
//   BYTE_LANES  : byte lanes per memory word (32-bit data path)
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  localparam int BYTE_LANES = 4;
  localparam int DATA_W     = BYTE_LANES * 8;

endpackage

// File: rtl/lsu_if.sv
// Interfaces for the load/store unit.
//   lsu_core_if : core-side request/response channel
//                 master = core (drives req_*, addr, wdata)
//                 slave  = LSU  (drives req_ready, stall, resp_*)
//   lsu_mem_if  : data-memory bus
//                 master = LSU    (drives mem_req/we/addr/be/wdata)
//                 slave  = memory (drives mem_ack, mem_rdata)
interface lsu_core_if
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  mem_size_e        req_size;
  logic             req_unsigned;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             stall;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, addr, wdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, addr, wdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane formatter for the load/store unit.
// Inputs : size, is_unsigned, addr_lo (addr[1:0]), wdata (right-justified
//          store data), mem_rdata (raw memory word)
// Outputs: be (byte enables), wdata_rep (lane-replicated store data),
//          rdata_ext (aligned, sign/zero-extended load data),
//          misaligned (alignment fault or illegal size)
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_e          size,
  input  logic               is_unsigned,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [BYTE_LANES-1:0] be,
  output logic [DATA_W-1:0]  wdata_rep,
  output logic [DATA_W-1:0]  rdata_ext,
  output logic               misaligned
);

  logic [DATA_W-1:0] shifted;
  logic              sign_fill;

  // Bring the addressed byte/half down to bit 0.
  assign shifted = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = '0;
    wdata_rep  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    sign_fill  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        sign_fill  = ~is_unsigned & shifted[7];
        rdata_ext  = {{24{sign_fill}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        sign_fill  = ~is_unsigned & shifted[15];
        rdata_ext  = {{16{sign_fill}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
        // Only reached with addr_lo == 0, so shifted is the raw word.
        rdata_ext  = shifted;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage after the ALU.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   core     : lsu_core_if.slave - request (we/size/unsigned/addr/wdata),
//              req_ready, stall, one-cycle resp_valid with rdata/err
//   mem      : lsu_mem_if.master - req/ack data-memory bus
// Parameters:
//   WIDTH       : data/address width (32 only)
//   MEM_TIMEOUT : WAIT cycles without mem_ack before abort with error
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16
)(
  input  logic       clk,
  input  logic       rst,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  lsu_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             we_reg;
  mem_size_e        size_reg;
  logic             unsigned_reg;
  logic [1:0]       addr_lo_reg;

  logic             mem_req_reg;
  logic             mem_we_reg;
  logic [WIDTH-1:0] mem_addr_reg;
  logic [3:0]       mem_be_reg;
  logic [WIDTH-1:0] mem_wdata_reg;

  logic             resp_valid_reg;
  logic             resp_err_reg;
  logic [WIDTH-1:0] resp_rdata_reg;

  // The formatter sees the live request while IDLE (for the accept
  // decision and store lanes) and the latched request afterwards (for
  // aligning the returned load word).
  mem_size_e        sel_size;
  logic             sel_unsigned;
  logic [1:0]       sel_addr_lo;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_rdata;
  logic             al_misaligned;

  always_comb begin
    sel_size     = size_reg;
    sel_unsigned = unsigned_reg;
    sel_addr_lo  = addr_lo_reg;
    if (state_reg == IDLE) begin
      sel_size     = core.req_size;
      sel_unsigned = core.req_unsigned;
      sel_addr_lo  = core.addr[1:0];
    end
  end

  lsu_align u_align (
    .size        (sel_size),
    .is_unsigned (sel_unsigned),
    .addr_lo     (sel_addr_lo),
    .wdata       (core.wdata),
    .mem_rdata   (mem.mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      size_reg       <= SZ_BYTE;
      unsigned_reg   <= 1'b0;
      addr_lo_reg    <= 2'b00;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_be_reg     <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core.req_valid) begin
            we_reg       <= core.req_we;
            size_reg     <= core.req_size;
            unsigned_reg <= core.req_unsigned;
            addr_lo_reg  <= core.addr[1:0];
            if (al_misaligned) begin
              // Fault without touching memory; respond next cycle.
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
              state_reg      <= RESP;
            end else begin
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= core.req_we;
              mem_addr_reg  <= {core.addr[WIDTH-1:2], 2'b00};
              mem_be_reg    <= al_be;
              mem_wdata_reg <= al_wdata;
              cnt_reg       <= '0;
              state_reg     <= WAIT;
            end
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem.mem_ack) begin
            mem_req_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= we_reg ? '0 : al_rdata;
            state_reg      <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            mem_req_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
            resp_rdata_reg <= '0;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign core.req_ready  = (state_reg == IDLE);
  // Low in RESP so the core retires the instruction with the response.
  assign core.stall      = ((state_reg == IDLE) && core.req_valid) || (state_reg == WAIT);
  assign core.resp_valid = resp_valid_reg;
  assign core.resp_err   = resp_err_reg;
  assign core.resp_rdata = resp_rdata_reg;

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage that sits directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and size/sign controls from the decoder.
- Runs a req/ack transaction to data memory, formatting byte lanes for stores and aligning/extending load data for writeback.
- Stalls the single-stage core (PC and register writeback hold) until the access completes, faults on misalignment, or times out.

Parameters:
WIDTH, 32, address/data width; only 32 is supported (4 byte lanes).
MEM_TIMEOUT, 16, maximum cycles in WAIT without mem_ack before the access is aborted with an error; must be >= 1.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  core requests a load/store this cycle
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
addr  input  WIDTH  effective address (ALU result)
wdata  input  WIDTH  store data (rs2), right-justified
stall  output  1  hold PC/writeback
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  WIDTH  aligned, extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size, or timeout; valid with resp_valid
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  WIDTH  word-aligned address (addr with [1:0] = 0)
mem_be  output  4  byte enables
mem_wdata  output  WIDTH  lane-replicated store data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  WIDTH  read word, valid with mem_ack

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state = IDLE
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0
  - resp_valid, resp_err, resp_rdata = 0
  - timeout counter = 0
  - Applies in any state, including WAIT mid-transaction: mem_req drops at that edge, and no resp_valid is produced for the aborted access.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - If req_valid, latch req_we/size/unsigned/addr[1:0] and check the request.
  - Misaligned means: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - If misaligned: go to RESP with resp_err = 1 and no memory access.
  - Otherwise: load mem_* registers, set mem_req = 1, clear the counter, go to WAIT.
- WAIT:
  - mem_req and all mem_* outputs held stable.
  - Counter increments each cycle mem_ack is low.
  - If mem_ack (counter value irrelevant): capture formatted load data, drop mem_req, go to RESP with resp_err = 0.
  - Else if counter reaches MEM_TIMEOUT-1: drop mem_req, go to RESP with resp_err = 1 and resp_rdata = 0.
  - mem_ack and timeout in the same cycle: ack wins.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready = 0, so a new request is accepted the following cycle at the earliest.
- mem_ack is ignored outside WAIT.
- stall = (state == IDLE && req_valid) || state == WAIT. It is low in RESP so the core retires with the response.
- Latency:
  - Accept at edge 0; mem_req high after edge 0.
  - Ack in the first WAIT cycle gives resp_valid after edge 1.
  - Misaligned/illegal requests give resp_valid after edge 0.
- Store formatting:
  - byte: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = 0011 << addr[1:0]; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 1111; mem_wdata = wdata.
  - Stores return resp_rdata = 0.
- Load formatting:
  - Shift mem_rdata right by 8*addr[1:0].
  - Take the low 8 or 16 bits, then sign- or zero-extend per req_unsigned.
  - Word loads pass through.
  - mem_be for loads is the same lane pattern as stores (informational).
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg:
  - mem_size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL)
  - lsu_state_e (IDLE, WAIT, RESP)
  - BYTE_LANES = 4 constant
- Sub-module lsu_align (combinational):
  - Inputs: size, unsigned, addr[1:0], wdata, mem_rdata.
  - Outputs: be, replicated wdata, extended rdata, misaligned flag.
- The top holds only the FSM, counter and registers.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF with ack after 3 WAIT cycles -> mem_addr 0x100, mem_be 1111; resp_valid once with rdata 0xDEADBEEF, err 0; stall high for 4 cycles.
- LB addr 0x203, mem_rdata 0x80123456, immediate ack -> resp_rdata 0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x302, wdata 0x0000ABCD -> mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x300; resp_rdata 0.
- LW addr 0x102 -> mem_req never asserted; resp_valid with err 1 on the next cycle; req_size 11 gives the same result.
- LW with mem_ack held low, MEM_TIMEOUT 16 -> mem_req drops after 16 WAIT cycles; resp_err 1, resp_rdata 0; a later request completes normally.
- rst pulsed during WAIT of an LW -> mem_req 0 and state IDLE after that edge; no resp_valid; a late mem_ack is ignored.
